// File: rtl/load_use_lock_ctrl_pkg.sv
// Shared CPU constants used by the load-use lock controller:
// FSM state encoding, EX forward-select codes and operand selectors.
package load_use_lock_ctrl_pkg;

    // Lock controller FSM states
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_REPLAY = 1'b1;

    // EX operand mux forward-select codes
    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_WB   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_LOCK = 2'd3;

    // Operand selectors
    localparam logic RS1 = 1'b0;
    localparam logic RS2 = 1'b1;

    // True when the FSM is in the replay cycle
    function automatic logic is_replay(input logic [0:0] state);
        return (state == ST_REPLAY);
    endfunction

endpackage

// File: rtl/load_use_lock_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic         w_full;

    assign w_full  = &r_count;
    assign o_count = r_count;

    // Count enabled events until every bit is set, then hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/load_use_lock_ctrl.sv
// Load-use lock controller.
// On a load-use hazard the front of the pipeline is held for one cycle and a
// NOP is loaded into EX/MEM. If the other source operand was being forwarded
// from WB while stalled, that WB value is captured and presented on the
// replay cycle so the EX operand mux can pick it with forward code FWD_LOCK.
//
// Handshake: there is no valid/ready pair here. load_use_stall_flush is a
// level request sampled every cycle; a request is "taken" on a clock edge
// where the FSM is IDLE and neither mem_stall nor pipe_flush is high. The
// stall/bubble outputs answer the request combinationally in the same cycle.
module load_use_lock_ctrl
    import load_use_lock_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall_flush,
    input  logic             load_use_wb_lock_signal,
    input  logic             load_use_rs_lock_num,
    input  logic [XLEN-1:0]  WB_rd_data,
    input  logic             mem_stall,
    input  logic             pipe_flush,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_stall,
    output logic             exmem_bubble,
    output logic             lock_forward_signal,
    output logic             lock_forward_rs,
    output logic [XLEN-1:0]  lock_data,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             hazard_err,
    output logic [0:0]       dbg_state
);

    logic [0:0]      r_state;
    logic [0:0]      w_next_state;
    logic            r_lock_fwd;
    logic            r_lock_rs;
    logic [XLEN-1:0] r_lock_data;
    logic            r_hazard_err;

    logic            w_idle;
    logic            w_stall;
    logic            w_take;
    logic            w_replay_adv;
    logic            w_proto_err;

    // Decode of the current cycle's events
    assign w_idle       = !is_replay(r_state);
    assign w_stall      = w_idle & load_use_stall_flush & ~pipe_flush;
    // Hazard accepted: the pipeline advances out of the stall on this edge
    assign w_take       = w_stall & ~mem_stall;
    // Replay cycle completes when the pipeline is allowed to advance
    assign w_replay_adv = ~w_idle & ~mem_stall & ~pipe_flush;
    // MEM holds the bubble during replay, so a new hazard here is bogus
    assign w_proto_err  = ~w_idle & load_use_stall_flush & ~pipe_flush;

    assign pc_stall     = w_stall;
    assign ifid_stall   = w_stall;
    assign idex_stall   = w_stall;
    assign exmem_bubble = w_stall;

    assign lock_forward_signal = r_lock_fwd;
    assign lock_forward_rs     = r_lock_rs;
    assign lock_data           = r_lock_data;
    assign hazard_err          = r_hazard_err;
    assign dbg_state           = r_state;

    // Next-state selection; a flush always returns to IDLE
    always_comb begin
        w_next_state = r_state;
        if (pipe_flush) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        w_next_state = ST_REPLAY;
                    end
                end
                ST_REPLAY: begin
                    if (!mem_stall) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Lock-forward enable: set from the WB-lock request when a hazard is
    // taken, cleared when replay completes or the pipe is flushed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_fwd <= 1'b0;
        end else if (pipe_flush) begin
            r_lock_fwd <= 1'b0;
        end else if (w_take) begin
            r_lock_fwd <= load_use_wb_lock_signal;
        end else if (w_replay_adv) begin
            r_lock_fwd <= 1'b0;
        end
    end

    // Capture the WB value and operand select only when a lock is requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_data <= '0;
            r_lock_rs   <= RS1;
        end else if (w_take && load_use_wb_lock_signal) begin
            r_lock_data <= WB_rd_data;
            r_lock_rs   <= load_use_rs_lock_num;
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hazard_err <= 1'b0;
        end else if (w_proto_err) begin
            r_hazard_err <= 1'b1;
        end
    end

    // Count of load-use stalls actually taken
    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_take),
        .o_count (stall_cnt)
    );

endmodule

// File: tb/tb_load_use_lock_ctrl.sv
// Bench for load_use_lock_ctrl: directed vector table, hand-written reset and
// saturation sequences, then randomized traffic against a behavioural model.
module tb_load_use_lock_ctrl;

  logic        clk;
  logic        rst_n;
  logic        lusf;
  logic        wbl;
  logic        rsn;
  logic [31:0] wb_data;
  logic        ms;
  logic        pf;

  logic        pc_st, ifid_st, idex_st, exmem_bub;
  logic        lfs, lfr;
  logic [31:0] ld;
  logic [15:0] cnt;
  logic        err;
  logic [0:0]  st;

  logic        pc_st4, ifid_st4, idex_st4, exmem_bub4;
  logic        lfs4, lfr4;
  logic [31:0] ld4;
  logic [3:0]  cnt4;
  logic        err4;
  logic [0:0]  st4;

  int errors = 0;
  int checks = 0;

  // behavioural model
  bit          m_replay;
  bit          m_lfs;
  bit          m_lfr;
  logic [31:0] m_ld;
  int          m_cnt;
  bit          m_err;

  load_use_lock_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall_flush(lusf), .load_use_wb_lock_signal(wbl),
    .load_use_rs_lock_num(rsn), .WB_rd_data(wb_data),
    .mem_stall(ms), .pipe_flush(pf),
    .pc_stall(pc_st), .ifid_stall(ifid_st), .idex_stall(idex_st),
    .exmem_bubble(exmem_bub), .lock_forward_signal(lfs),
    .lock_forward_rs(lfr), .lock_data(ld), .stall_cnt(cnt),
    .hazard_err(err), .dbg_state(st)
  );

  load_use_lock_ctrl #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_use_stall_flush(lusf), .load_use_wb_lock_signal(wbl),
    .load_use_rs_lock_num(rsn), .WB_rd_data(wb_data),
    .mem_stall(ms), .pipe_flush(pf),
    .pc_stall(pc_st4), .ifid_stall(ifid_st4), .idex_stall(idex_st4),
    .exmem_bubble(exmem_bub4), .lock_forward_signal(lfs4),
    .lock_forward_rs(lfr4), .lock_data(ld4), .stall_cnt(cnt4),
    .hazard_err(err4), .dbg_state(st4)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        lusf;
    logic        wbl;
    logic        rs;
    logic [31:0] data;
    logic        ms;
    logic        pf;
    logic        st;
    logic        stall;
    logic        lfs;
    logic        lfr;
    logic [31:0] ld;
    logic [15:0] cnt;
    logic        err;
  } vec_t;

  localparam int NVEC = 23;
  vec_t tbl [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a_lusf, input logic a_wbl, input logic a_rs,
                       input logic [31:0] a_data, input logic a_ms, input logic a_pf);
    lusf    = a_lusf;
    wbl     = a_wbl;
    rsn     = a_rs;
    wb_data = a_data;
    ms      = a_ms;
    pf      = a_pf;
  endtask

  task automatic model_reset();
    m_replay = 0;
    m_lfs    = 0;
    m_lfr    = 0;
    m_ld     = '0;
    m_cnt    = 0;
    m_err    = 0;
  endtask

  // One hazard occupies one stall cycle plus one replay cycle; a flush
  // cancels everything in flight; a request during replay is a violation.
  task automatic model_edge();
    if (pf) begin
      m_replay = 0;
      m_lfs    = 0;
    end else if (!m_replay) begin
      if (lusf && !ms) begin
        m_replay = 1;
        m_cnt++;
        m_lfs = wbl;
        if (wbl) begin
          m_ld  = wb_data;
          m_lfr = rsn;
        end
      end
    end else begin
      if (lusf) m_err = 1;
      if (!ms) begin
        m_replay = 0;
        m_lfs    = 0;
      end
    end
  endtask

  // Advance one clock, update the model with the inputs seen at the edge
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 32'h0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    bit          exp_stall;
    int          c16;
    int          c4;
    exp_stall = !m_replay && lusf && !pf;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c4  = (m_cnt > 15) ? 15 : m_cnt;
    chk({tag, " stall"}, {60'd0, pc_st, ifid_st, idex_st, exmem_bub}, {60'd0, {4{exp_stall}}});
    chk({tag, " stall4"}, {60'd0, pc_st4, ifid_st4, idex_st4, exmem_bub4}, {60'd0, {4{exp_stall}}});
    chk({tag, " lfs"}, {63'd0, lfs}, {63'd0, m_lfs});
    chk({tag, " lfr"}, {63'd0, lfr}, {63'd0, m_lfr});
    chk({tag, " ld"}, {32'd0, ld}, {32'd0, m_ld});
    chk({tag, " cnt16"}, {48'd0, cnt}, 64'(c16));
    chk({tag, " cnt4"}, {60'd0, cnt4}, 64'(c4));
    chk({tag, " err"}, {63'd0, err}, {63'd0, m_err});
    chk({tag, " lfs4"}, {62'd0, lfs4, ld4 == ld}, {62'd0, m_lfs, 1'b1});
  endtask

  initial begin
    // lusf wbl rs data ms pf | st stall lfs lfr ld cnt err
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        16'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        16'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        16'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        16'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 16'd2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 16'd2, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd2, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h11111111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd2, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 16'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22222222, 16'd3, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22222222, 16'd3, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h22222222, 16'd3, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22222222, 16'd3, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22222222, 16'd3, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33333333, 16'd4, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 16'd4, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 16'd4, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 16'd4, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h33333333, 16'd4, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h33333333, 16'd5, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 16'd5, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h33333333, 16'd5, 1'b1};

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 0);
    model_reset();
    #2;
    // reset state while reset is held
    chk("reset_state", {54'd0, st, lfs, lfr, err, pc_st, ifid_st, idex_st, exmem_bub, cnt4},
        64'd0);
    chk("reset_data", {16'd0, cnt, ld}, 64'd0);
    do_reset();

    // directed vector table
    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].lusf, tbl[i].wbl, tbl[i].rs, tbl[i].data, tbl[i].ms, tbl[i].pf);
      @(negedge clk);
      chk($sformatf("vec%0d state", i), {63'd0, st}, {63'd0, tbl[i].st});
      chk($sformatf("vec%0d stall", i), {60'd0, pc_st, ifid_st, idex_st, exmem_bub},
          {60'd0, {4{tbl[i].stall}}});
      chk($sformatf("vec%0d lock", i), {30'd0, lfs, lfr, ld}, {30'd0, tbl[i].lfs, tbl[i].lfr, tbl[i].ld});
      chk($sformatf("vec%0d cnt", i), {48'd0, cnt}, {48'd0, tbl[i].cnt});
      chk($sformatf("vec%0d cnt4", i), {60'd0, cnt4}, {60'd0, tbl[i].cnt[3:0]});
      chk($sformatf("vec%0d err", i), {63'd0, err}, {63'd0, tbl[i].err});
      tick();
    end

    // asynchronous reset in the middle of a replay cycle
    drive(1, 1, 1, 32'hAAAA5555, 0, 0);
    tick();
    drive(0, 0, 0, 32'h0, 0, 0);
    @(negedge clk);
    chk("pre_rst replay", {62'd0, st, lfs}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst regs", {54'd0, st, lfs, lfr, err, pc_st, ifid_st, idex_st, exmem_bub, cnt4}, 64'd0);
    chk("async_rst data", {16'd0, cnt, ld}, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // saturation: 17 hazards
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 32'h0, 0, 0);
      tick();
      drive(0, 0, 0, 32'h0, 0, 0);
      tick();
    end
    @(negedge clk);
    chk("sat cnt4", {60'd0, cnt4}, 64'hF);
    chk("sat cnt16", {48'd0, cnt}, 64'd17);
    check_model("sat");

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1,
            $urandom,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
